// File: rtl/guess_history_buf_pkg.sv
// Shared definitions for the guess history buffer: FSM state encoding,
// button event indices, the edge-detector history reset value and a
// constant clog2 used to size the buffer ports.
package hist_pkg;

  typedef enum logic {
    HIST_GUESS  = 1'b0,
    HIST_BROWSE = 1'b1
  } hist_state_t;

  // History registers start high so a button held through reset release
  // does not look like a fresh press.
  localparam logic EDGE_HIST_RST = 1'b1;

  // Bit positions inside the button/event vector.
  localparam int unsigned BTN_UP   = 0;
  localparam int unsigned BTN_DOWN = 1;
  localparam int unsigned BTN_SEL  = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/guess_history_buf_edge_det.sv
// Rising-edge detector for a vector of debounced button levels.
// evt[i] is high for the cycle in which level[i] is 1 and the previous
// sample was 0.
module hist_edge_det
  import hist_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] level,
  output logic [W-1:0] evt
);

  logic [W-1:0] prev;

  // Previous-sample history, reset high to suppress events from held buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= {W{EDGE_HIST_RST}};
    else        prev <= level;
  end

  // Event is the current level gated by the previous low sample.
  always_comb begin
    evt = level & ~prev;
  end

endmodule

// File: rtl/guess_history_buf.sv
// Turn-history store for the code-breaking game: records committed guesses
// into a MAX_TURNS-deep buffer and lets the player browse past turns.
// Optional feature macro: HIST_FEEDBACK_EN stores black/white feedback with
// each entry and shows it for the browsed turn; when undefined the fb inputs
// are unused and sel_fb_* are tied to zero.
module guess_history_buf
  import hist_pkg::*;
#(
  parameter  int PEGS      = 4,
  parameter  int COLOR_W   = 3,
  parameter  int MAX_TURNS = 8,
  localparam int TURN_W    = clog2(MAX_TURNS),
  localparam int CNT_W     = clog2(MAX_TURNS + 1),
  localparam int FB_W      = clog2(PEGS + 1),
  localparam int GW        = PEGS * COLOR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_select,
  input  logic [GW-1:0]     guess,
  input  logic [FB_W-1:0]   fb_black,
  input  logic [FB_W-1:0]   fb_white,
  output logic [GW-1:0]     selection,
  output logic [FB_W-1:0]   sel_fb_black,
  output logic [FB_W-1:0]   sel_fb_white,
  output logic [TURN_W-1:0] selected_turn,
  output logic [CNT_W-1:0]  num_turns,
  output logic              last_turn,
  output logic              full,
  output logic              commit_ack
);

  hist_state_t       state, state_next;
  logic [TURN_W-1:0] cursor, cursor_next;
  logic [CNT_W-1:0]  num_next;
  logic              wr_en;
  logic [TURN_W-1:0] wr_idx;
  logic [2:0]        evt;
  logic [GW-1:0]     mem_guess [MAX_TURNS];
  logic              rd_valid;
  logic              rd_bypass;
  logic [GW-1:0]     rd_guess;
  logic [TURN_W-1:0] guess_turn;

  hist_edge_det #(
    .W(3)
  ) u_edge (
    .clk  (clk),
    .reset(reset),
    .level({btn_select, btn_down, btn_up}),
    .evt  (evt)
  );

  assign wr_idx = num_turns[TURN_W-1:0];

  // FSM state and browse cursor registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= HIST_GUESS;
      cursor <= '0;
    end else begin
      state  <= state_next;
      cursor <= cursor_next;
    end
  end

  // Next state, cursor, count and write enable; events use the pre-change state.
  always_comb begin
    state_next  = state;
    cursor_next = cursor;
    num_next    = num_turns;
    wr_en       = 1'b0;
    if (clear) begin
      state_next  = HIST_GUESS;
      cursor_next = '0;
      num_next    = '0;
    end else begin
      unique case (state)
        HIST_GUESS: begin
          if (evt[BTN_SEL] && !full) begin
            wr_en    = 1'b1;
            num_next = num_turns + 1'b1;
          end
          if (mode) begin
            state_next  = HIST_BROWSE;
            cursor_next = (num_next == '0) ? '0 : TURN_W'(num_next - 1'b1);
          end
        end
        HIST_BROWSE: begin
          if (evt[BTN_UP] && !evt[BTN_DOWN] &&
              ((CNT_W'(cursor) + 1'b1) < num_turns)) begin
            cursor_next = cursor + 1'b1;
          end else if (evt[BTN_DOWN] && !evt[BTN_UP] && (cursor != '0)) begin
            cursor_next = cursor - 1'b1;
          end
          if (!mode) state_next = HIST_GUESS;
        end
        default: state_next = HIST_GUESS;
      endcase
    end
  end

  // Entry storage; contents survive clear and are masked on read instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem_guess[wr_idx] <= guess;
  end

  // Read of the next displayed entry; bypass covers a commit that coincides
  // with entering BROWSE, where the cursor lands on the slot being written.
  always_comb begin
    rd_valid  = CNT_W'(cursor_next) < num_next;
    rd_bypass = wr_en && (cursor_next == wr_idx);
    rd_guess  = '0;
    if (rd_valid) rd_guess = rd_bypass ? guess : mem_guess[cursor_next];
    guess_turn = (num_next >= CNT_W'(MAX_TURNS - 1)) ? TURN_W'(MAX_TURNS - 1)
                                                     : num_next[TURN_W-1:0];
  end

  // Registered outputs, computed from the post-edge state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      selection     <= '0;
      selected_turn <= '0;
      num_turns     <= '0;
      last_turn     <= 1'b0;
      full          <= 1'b0;
      commit_ack    <= 1'b0;
    end else begin
      commit_ack <= wr_en;
      num_turns  <= num_next;
      full       <= (num_next == CNT_W'(MAX_TURNS));
      last_turn  <= (num_next == CNT_W'(MAX_TURNS - 1));
      if (state_next == HIST_GUESS) begin
        selection     <= guess;
        selected_turn <= guess_turn;
      end else begin
        selection     <= rd_guess;
        selected_turn <= cursor_next;
      end
    end
  end

`ifdef HIST_FEEDBACK_EN
  logic [FB_W-1:0] mem_fb_black [MAX_TURNS];
  logic [FB_W-1:0] mem_fb_white [MAX_TURNS];
  logic [FB_W-1:0] rd_fb_black, rd_fb_white;

  // Feedback storage alongside each guess.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_fb_black[wr_idx] <= fb_black;
      mem_fb_white[wr_idx] <= fb_white;
    end
  end

  // Feedback read with the same masking and bypass as the guess read.
  always_comb begin
    rd_fb_black = '0;
    rd_fb_white = '0;
    if (rd_valid) begin
      rd_fb_black = rd_bypass ? fb_black : mem_fb_black[cursor_next];
      rd_fb_white = rd_bypass ? fb_white : mem_fb_white[cursor_next];
    end
  end

  // Feedback outputs: stored values in BROWSE, zero in GUESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_fb_black <= '0;
      sel_fb_white <= '0;
    end else if (state_next == HIST_BROWSE) begin
      sel_fb_black <= rd_fb_black;
      sel_fb_white <= rd_fb_white;
    end else begin
      sel_fb_black <= '0;
      sel_fb_white <= '0;
    end
  end
`else
  logic fb_unused;
  assign fb_unused    = ^{fb_black, fb_white};
  assign sel_fb_black = '0;
  assign sel_fb_white = '0;
`endif

endmodule

// File: tb/tb_guess_history_buf.sv
// Self-checking bench for guess_history_buf (default build, feedback storage
// disabled). Expected output snapshots are queued as stimulus is driven and
// compared one cycle later, 1 time unit after the rising edge.
module tb_guess_history_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        mode = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_select = 1'b0;
  logic [11:0] guess = '0;
  logic [2:0]  fb_black = '0;
  logic [2:0]  fb_white = '0;
  logic [11:0] selection;
  logic [2:0]  sel_fb_black, sel_fb_white;
  logic [2:0]  selected_turn;
  logic [3:0]  num_turns;
  logic        last_turn, full, commit_ack;

  typedef struct packed {
    logic        ack;
    logic        full;
    logic        last;
    logic [3:0]  num;
    logic [2:0]  turn;
    logic [11:0] sel;
    logic [2:0]  fbb;
    logic [2:0]  fbw;
  } obs_t;

  typedef struct packed {
    logic       up;
    logic       dn;
    logic       sl;
    logic       md;
    logic [2:0] turn;
    logic [3:0] gi;   // index into G, 8 = live guess
  } step_t;

  obs_t        exp_q[$];
  obs_t        e, a;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] G [8] = '{12'o1000, 12'o2211, 12'o3322, 12'o4433,
                         12'o5544, 12'o6655, 12'o7766, 12'o0777};

  guess_history_buf #(
    .PEGS(4),
    .COLOR_W(3),
    .MAX_TURNS(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .mode         (mode),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_select   (btn_select),
    .guess        (guess),
    .fb_black     (fb_black),
    .fb_white     (fb_white),
    .selection    (selection),
    .sel_fb_black (sel_fb_black),
    .sel_fb_white (sel_fb_white),
    .selected_turn(selected_turn),
    .num_turns    (num_turns),
    .last_turn    (last_turn),
    .full         (full),
    .commit_ack   (commit_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic obs_t mk(logic ack, logic fl, logic lt, logic [3:0] num,
                              logic [2:0] turn, logic [11:0] sel);
    return '{ack, fl, lt, num, turn, sel, 3'd0, 3'd0};
  endfunction

  function automatic obs_t obs();
    return '{commit_ack, full, last_turn, num_turns, selected_turn, selection,
             sel_fb_black, sel_fb_white};
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("ack=%b full=%b last=%b num=%0d turn=%0d sel=%o fb=%0d/%0d",
                     o.ack, o.full, o.last, o.num, o.turn, o.sel, o.fbb, o.fbw);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    btn_select = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, '0));
    e = exp_q.pop_front(); a = obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL reset_state got %s want %s", fmt(a), fmt(e)); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, guess));
      tick();
      e = exp_q.pop_front(); a = obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL held_select_reset cyc%0d got %s want %s", i, fmt(a), fmt(e)); end
    end
    btn_select = 1'b0;
    tick();
  endtask

  task automatic test_first_commit();
    guess = 12'o1000; fb_black = 3'd1; fb_white = 3'd0;
    btn_select = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 1, 1, 12'o1000));
    tick();
    e = exp_q.pop_front(); a = obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL first_commit got %s want %s", fmt(a), fmt(e)); end
    btn_select = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 1, 1, 12'o1000));
    tick();
    e = exp_q.pop_front(); a = obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL first_commit_ack_drop got %s want %s", fmt(a), fmt(e)); end
  endtask

  task automatic test_fill();
    int n;
    clear = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, guess));
    tick();
    e = exp_q.pop_front(); a = obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL fill_clear got %s want %s", fmt(a), fmt(e)); end
    clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n = i + 1;
      guess = G[i];
      btn_select = 1'b1;
      exp_q.push_back(mk(1, n == 8, n == 7, 4'(n), (n > 7) ? 3'd7 : 3'(n), G[i]));
      tick();
      btn_select = 1'b0;
      exp_q.push_back(mk(0, n == 8, n == 7, 4'(n), (n > 7) ? 3'd7 : 3'(n), G[i]));
      e = exp_q.pop_front(); a = obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL fill_commit%0d got %s want %s", n, fmt(a), fmt(e)); end
      tick();
      e = exp_q.pop_front(); a = obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL fill_release%0d got %s want %s", n, fmt(a), fmt(e)); end
    end
    guess = 12'o5555;
    btn_select = 1'b1;
    exp_q.push_back(mk(0, 1, 0, 8, 7, 12'o5555));
    tick();
    e = exp_q.pop_front(); a = obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL fill_ninth_select got %s want %s", fmt(a), fmt(e)); end
    btn_select = 1'b0;
    tick();
  endtask

  task automatic test_browse();
    step_t steps [21];
    steps = '{
      '{0,0,0,1,3'd2,4'd2}, '{0,1,0,1,3'd1,4'd1}, '{0,0,0,1,3'd1,4'd1},
      '{0,1,0,1,3'd0,4'd0}, '{0,0,0,1,3'd0,4'd0}, '{0,1,0,1,3'd0,4'd0},
      '{0,0,0,1,3'd0,4'd0}, '{1,0,0,1,3'd1,4'd1}, '{0,0,0,1,3'd1,4'd1},
      '{1,0,0,1,3'd2,4'd2}, '{0,0,0,1,3'd2,4'd2}, '{1,0,0,1,3'd2,4'd2},
      '{0,0,0,1,3'd2,4'd2}, '{1,0,0,1,3'd2,4'd2}, '{0,0,0,1,3'd2,4'd2},
      '{0,1,0,1,3'd1,4'd1}, '{0,0,0,1,3'd1,4'd1}, '{1,1,0,1,3'd1,4'd1},
      '{0,0,0,1,3'd1,4'd1}, '{0,0,1,1,3'd1,4'd1}, '{0,0,0,0,3'd3,4'd8}
    };
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      guess = G[i];
      btn_select = 1'b1;
      exp_q.push_back(mk(1, 0, 0, 4'(i + 1), 3'(i + 1), G[i]));
      tick();
      btn_select = 1'b0;
      e = exp_q.pop_front(); a = obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL browse_setup_commit%0d got %s want %s", i, fmt(a), fmt(e)); end
      tick();
    end
    guess = 12'o7070;
    foreach (steps[i]) begin
      btn_up = steps[i].up; btn_down = steps[i].dn;
      btn_select = steps[i].sl; mode = steps[i].md;
      exp_q.push_back(mk(0, 0, 0, 3, steps[i].turn,
                         (steps[i].gi == 4'd8) ? guess : G[steps[i].gi[2:0]]));
      tick();
      e = exp_q.pop_front(); a = obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL browse_step%0d got %s want %s", i, fmt(a), fmt(e)); end
    end
  endtask

  task automatic test_hold_select();
    guess = G[3];
    btn_select = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(mk(k == 0, 0, 0, 4, 4, G[3]));
      tick();
      e = exp_q.pop_front(); a = obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL hold_select cyc%0d got %s want %s", k, fmt(a), fmt(e)); end
    end
    btn_select = 1'b0;
    tick();
  endtask

  task automatic test_clear_with_select();
    guess = 12'o1234;
    clear = 1'b1; btn_select = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 12'o1234));
    tick();
    e = exp_q.pop_front(); a = obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL clear_over_select got %s want %s", fmt(a), fmt(e)); end
    clear = 1'b0; btn_select = 1'b0;
    tick();
    mode = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 12'o0000));
    tick();
    e = exp_q.pop_front(); a = obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL browse_after_clear got %s want %s", fmt(a), fmt(e)); end
    mode = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 12'o1234));
    tick();
    e = exp_q.pop_front(); a = obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL guess_after_clear got %s want %s", fmt(a), fmt(e)); end
  endtask

  task automatic test_no_feedback();
    guess = G[5]; fb_black = 3'd2; fb_white = 3'd1;
    btn_select = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 1, 1, G[5]));
    tick();
    e = exp_q.pop_front(); a = obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL nofb_commit got %s want %s", fmt(a), fmt(e)); end
    btn_select = 1'b0; mode = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 1, 0, G[5]));
    tick();
    e = exp_q.pop_front(); a = obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL nofb_browse got %s want %s", fmt(a), fmt(e)); end
    mode = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 1, 1, G[5]));
    tick();
    e = exp_q.pop_front(); a = obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL nofb_guess got %s want %s", fmt(a), fmt(e)); end
  endtask

  initial begin
    test_reset();
    test_first_commit();
    test_fill();
    test_browse();
    test_hold_select();
    test_clear_with_select();
    test_no_feedback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_history_buf.md
# guess_history_buf

Parametrised turn-history store for the code-breaking game. It records each committed guess, and optionally its black/white feedback, into a MAX_TURNS-deep buffer. It also lets the player browse past turns with the up/down buttons while in history mode. It sits between the button/switch front end and the display mux, and replaces the fixed 4-peg, 3-bit, single-mode history block with configurable peg count, colour width and depth, edge-detected buttons, saturating browse and a new-game clear.

## Interface
Parameters:
- PEGS, 4, pegs per guess
- COLOR_W, 3, bits per peg colour
- MAX_TURNS, 8, buffer depth in turns (≥2)
- derived: TURN_W = clog2(MAX_TURNS), CNT_W = clog2(MAX_TURNS+1), FB_W = clog2(PEGS+1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous new-game clear, level
- mode  in  1  0 = GUESS, 1 = BROWSE
- btn_up / btn_down / btn_select  in  1 each  debounced button levels
- guess  in  PEGS*COLOR_W  live guess, peg 0 in LSBs
- fb_black / fb_white  in  FB_W each  feedback for the guess being committed
- selection  out  PEGS*COLOR_W  displayed guess
- sel_fb_black / sel_fb_white  out  FB_W each  feedback of the displayed turn
- selected_turn  out  TURN_W  index of the displayed turn
- num_turns  out  CNT_W  committed entries
- last_turn  out  1  num_turns == MAX_TURNS-1, so the next commit is final
- full  out  1  num_turns == MAX_TURNS
- commit_ack  out  1  one-cycle pulse per accepted commit

## Operation
- Buttons are rising-edge detected internally. An event fires on a cycle where the input is sampled 1 and the previous sample was 0.
- FSM states are GUESS and BROWSE.
  - GUESS→BROWSE when mode is sampled 1. The cursor loads num_turns-1, or 0 if the buffer is empty.
  - BROWSE→GUESS when mode is sampled 0.
- GUESS behaviour:
  - selection follows guess; selected_turn = min(num_turns, MAX_TURNS-1).
  - A select event with full=0 writes {guess, fb} to mem[num_turns], increments num_turns and pulses commit_ack.
  - A select event with full=1 is ignored: no write, no ack.
  - Up/down events are ignored.
- BROWSE behaviour:
  - selection shows mem[cursor]; selected_turn = cursor.
  - An up event increments the cursor, saturating at num_turns-1. A down event decrements it, saturating at 0.
  - Simultaneous up and down events leave the cursor unchanged.
  - Select events are ignored.
  - With num_turns = 0, selection and sel_fb read as all zeros.
- Mode change in the same cycle as a button event: the event is evaluated in the pre-change state.
- clear:
  - Sets num_turns=0, cursor=0 and state=GUESS.
  - Overrides every other event in the same cycle; commit_ack is not pulsed.
  - Memory contents are not erased. Reads of any index ≥ num_turns return zeros.
- Reset values:
  - All outputs are 0; state is GUESS; cursor is 0.
  - Edge-detector history registers reset to 1, so a button held through reset release produces no event.

## Timing
- All outputs are registered.
- An event sampled at edge n is visible at outputs after edge n. This covers commit, cursor move, clear and the num_turns/full/last_turn update.
- In GUESS, selection lags guess by one cycle.
- commit_ack is high exactly for the cycle following the accepting edge.
- A button held high produces one event only. The button must return to 0 for at least one cycle before it can fire again.
- Reset asserts asynchronously. Deassertion must be synchronised externally to clk.

## Configuration
- HIST_FEEDBACK_EN defined:
  - fb_black/fb_white are stored with every entry.
  - sel_fb_* show the stored feedback of the displayed turn in BROWSE and 0 in GUESS.
- HIST_FEEDBACK_EN undefined:
  - No feedback storage is built; fb inputs are unused; sel_fb_* are tied to 0.
  - The port list is unchanged in both builds.

## Structure
- Package hist_pkg holds:
  - the state enum (HIST_GUESS, HIST_BROWSE)
  - a clog2 function
  - localparams for the reset value of the edge-detector history
- Sub-module hist_edge_det:
  - parameter W, instantiated once with W=3 for up/down/select
  - inputs clk and reset; output is a one-cycle event vector
- Top level holds the FSM, cursor/count registers, storage array and output registers.

## Test plan
- Reset, then commit guess=12'o1000 with fb 1/0 → num_turns=1, commit_ack for 1 cycle, last_turn=0; in GUESS, selected_turn=1.
- Commit 8 distinct guesses (MAX_TURNS=8) → last_turn=1 after the 7th, full=1 after the 8th; a 9th select gives no ack, num_turns stays 8.
- After 3 commits, mode=1 → selected_turn=2, selection=3rd guess; 3 down events → cursor 2,1,0,0; 4 up events → 1,2,2,2.
- Hold btn_select high for 5 cycles → exactly one commit; btn_up and btn_down rising together in BROWSE → cursor unchanged.
- Pulse clear in the same cycle as a select event with 4 entries → num_turns=0, no ack, state GUESS; BROWSE then shows selection=0 and selected_turn=0.
- Hold btn_select high across reset release → no commit. Build without HIST_FEEDBACK_EN → sel_fb_* stay 0 after commits with fb 2/1.
